call_frame_ctrl: RTL

//  Call-frame controller sitting directly upstream of SuperStack. On CALL it saves the

---
 rtl/call_frame_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/call_frame_ctrl.sv
// rtl/call_frame_ctrl.sv - call-frame controller upstream of SuperStack
module call_frame_ctrl #(
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call,
  input  logic                  ret,
  input  logic [PC_WIDTH-1:0]   ret_pc_in,
  input  logic [DEPTH:0]        num_args,
  input  logic                  has_result,
  input  logic [DEPTH:0]        stack_index,
  input  logic [DATA_WIDTH-1:0] stack_top,
  output logic [DEPTH:0]        underflow_limit,
  output logic [2:0]            stk_op,
  output logic [DEPTH:0]        stk_new_index,
  output logic [DATA_WIDTH-1:0] stk_data,
  output logic [PC_WIDTH-1:0]   ret_pc_out,
  output logic [FRAME_BITS:0]   frame_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int NF = 2 ** FRAME_BITS;

  // SuperStack op encodings
  localparam logic [2:0] OP_NONE                 = 3'd0;
  localparam logic [2:0] OP_INDEX_RESET          = 3'd5;
  localparam logic [2:0] OP_INDEX_RESET_AND_PUSH = 3'd6;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_ARGS     = 2'd2;
  localparam logic [1:0] ERR_NOFRAME  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RET_READ, S_RET_ISSUE, S_RET_DONE} state_t;

  state_t state, state_n;

  logic [PC_WIDTH-1:0]   mem_pc    [NF];
  logic [DEPTH:0]        mem_limit [NF];
  logic [DEPTH:0]        mem_base  [NF];

  logic [DEPTH:0]        underflow_limit_n, stk_new_index_n;
  logic [2:0]            stk_op_n;
  logic [DATA_WIDTH-1:0] stk_data_n;
  logic [PC_WIDTH-1:0]   ret_pc_out_n;
  logic [FRAME_BITS:0]   frame_count_n;
  logic                  busy_n, done_n, error_n;
  logic [1:0]            err_code_n;

  logic                  res_q, res_n;
  logic [PC_WIDTH-1:0]   sv_pc, sv_pc_n;
  logic [DEPTH:0]        sv_limit, sv_limit_n, sv_base, sv_base_n;

  logic                  wr_en;
  logic [DEPTH:0]        avail, new_base;
  logic [FRAME_BITS:0]   top;
  logic                  frame_full;

  assign avail      = stack_index - underflow_limit;
  assign new_base   = stack_index - num_args;
  assign top        = frame_count - 1'b1;
  assign frame_full = (frame_count == (FRAME_BITS+1)'(NF));

  always_comb begin
    state_n           = state;
    underflow_limit_n = underflow_limit;
    stk_op_n          = OP_NONE;
    stk_new_index_n   = stk_new_index;
    stk_data_n        = stk_data;
    ret_pc_out_n      = ret_pc_out;
    frame_count_n     = frame_count;
    done_n            = 1'b0;
    error_n           = 1'b0;
    err_code_n        = ERR_NONE;
    res_n             = res_q;
    sv_pc_n           = sv_pc;
    sv_limit_n        = sv_limit;
    sv_base_n         = sv_base;
    wr_en             = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (call && ret) begin
          error_n    = 1'b1;
          err_code_n = ERR_NOFRAME;
        end else if (call) begin
          if (frame_full) begin
            error_n    = 1'b1;
            err_code_n = ERR_OVERFLOW;
          end else if (num_args > avail) begin
            error_n    = 1'b1;
            err_code_n = ERR_ARGS;
          end else begin
            wr_en             = 1'b1;
            frame_count_n     = frame_count + 1'b1;
            underflow_limit_n = new_base;
            done_n            = 1'b1;
          end
        end else if (ret) begin
          if (frame_count == '0) begin
            error_n    = 1'b1;
            err_code_n = ERR_NOFRAME;
          end else begin
            res_n   = has_result;
            state_n = S_RET_READ;
          end
        end
      end
      S_RET_READ: begin
        sv_pc_n    = mem_pc[top[FRAME_BITS-1:0]];
        sv_limit_n = mem_limit[top[FRAME_BITS-1:0]];
        sv_base_n  = mem_base[top[FRAME_BITS-1:0]];
        stk_data_n = stack_top;
        state_n    = S_RET_ISSUE;
      end
      S_RET_ISSUE: begin
        // Limit and index move on the same edge so SuperStack never sees a mixed frame
        stk_op_n          = res_q ? OP_INDEX_RESET_AND_PUSH : OP_INDEX_RESET;
        stk_new_index_n   = sv_base;
        underflow_limit_n = sv_limit;
        ret_pc_out_n      = sv_pc;
        frame_count_n     = top;
        state_n           = S_RET_DONE;
      end
      S_RET_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      underflow_limit <= '0;
      stk_op          <= OP_NONE;
      stk_new_index   <= '0;
      stk_data        <= '0;
      ret_pc_out      <= '0;
      frame_count     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_code        <= ERR_NONE;
      res_q           <= 1'b0;
      sv_pc           <= '0;
      sv_limit        <= '0;
      sv_base         <= '0;
    end else begin
      state           <= state_n;
      underflow_limit <= underflow_limit_n;
      stk_op          <= stk_op_n;
      stk_new_index   <= stk_new_index_n;
      stk_data        <= stk_data_n;
      ret_pc_out      <= ret_pc_out_n;
      frame_count     <= frame_count_n;
      busy            <= busy_n;
      done            <= done_n;
      error           <= error_n;
      err_code        <= err_code_n;
      res_q           <= res_n;
      sv_pc           <= sv_pc_n;
      sv_limit        <= sv_limit_n;
      sv_base         <= sv_base_n;
    end
  end

  // Frame storage needs no reset: frame_count gates every read
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_pc[frame_count[FRAME_BITS-1:0]]    <= ret_pc_in;
      mem_limit[frame_count[FRAME_BITS-1:0]] <= underflow_limit;
      mem_base[frame_count[FRAME_BITS-1:0]]  <= new_base;
    end
  end

endmodule
